sync_fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one `sync_fifo_fwft_with_clear` write port between `NUM_REQ` independent producers. Each producer uses a valid/ready handshake, and the arbiter forwards at most one word per cycle into the FIFO. The arbiter also sequences FIFO flushes: it drives the FIFO clear and blocks all producers while the clear is in progress. It sits directly in front of the FIFO write interface; the FIFO read side is untouched.

---
 rtl/sync_fifo_write_arbiter_pkg.sv | 19 +
 rtl/sync_fifo_write_arbiter_if.sv | 26 ++
 rtl/rr_priority_arbiter.sv | 38 +++
 rtl/sync_fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_sync_fifo_write_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_write_arbiter_pkg.sv
// rtl/sync_fifo_write_arbiter_pkg.sv - shared types, limits and sizing helper for the FIFO write arbiter
package sync_fifo_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_CLR    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int NUM_REQ_MAX = 16;

    // Width of a producer index; never narrower than one bit.
    function automatic int ptr_width(input int num_req);
        int n;
        n = (num_req > NUM_REQ_MAX) ? NUM_REQ_MAX : num_req;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo_write_arbiter_if.sv
// rtl/sync_fifo_write_arbiter_if.sv - producer and FIFO write-side signal bundle for the arbiter
interface sync_fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            i_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            i_last;
    logic [NUM_REQ-1:0]            o_ready;
    logic                          i_flush;
    logic                          o_fifo_wr_en;
    logic [DATA_WIDTH-1:0]         o_fifo_wr_data;
    logic                          i_fifo_full;
    logic                          o_fifo_clr;
    logic                          o_busy;

    modport slave (
        input  i_valid, i_data, i_last, i_flush, i_fifo_full,
        output o_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_clr, o_busy
    );

    modport master (
        output i_valid, i_data, i_last, i_flush, i_fifo_full,
        input  o_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_clr, o_busy
    );
endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_priority_arbiter
    import sync_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;

    // Rotate requests so bit 0 is the producer at ptr, take the lowest set bit, then un-rotate.
    always_comb begin
        w_dbl       = {i_req, i_req} >> i_ptr;
        w_rot       = w_dbl[NUM_REQ-1:0];
        w_off       = '0;
        o_grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_grant_vld && w_rot[i]) begin
                o_grant_vld = 1'b1;
                w_off       = PTR_W'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
        end
        o_grant_idx = w_sum[PTR_W-1:0];
        o_grant     = o_grant_vld ? (NUM_REQ'(1) << o_grant_idx) : '0;
    end
endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// rtl/sync_fifo_write_arbiter.sv - round-robin FIFO write arbiter with flush sequencing; FIFO_ARB_LOCK_EN adds burst lock
module sync_fifo_write_arbiter
    import sync_fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sync_fifo_write_arbiter_if.slave bus
);
    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic                 r_clr;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic                 w_grant_vld;
    logic                 w_run;
    logic                 w_wr_en;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [DATA_WIDTH-1:0] w_wr_data;

`ifdef FIFO_ARB_LOCK_EN
    logic                 r_locked;
    logic [PTR_W-1:0]     r_lock_idx;

    // While a burst is open only the owning producer may be granted.
    always_comb begin
        w_req = bus.i_valid;
        if (r_locked) begin
            w_req = bus.i_valid & (NUM_REQ'(1) << r_lock_idx);
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^bus.i_last;
    assign w_req         = bus.i_valid;
`endif

    rr_priority_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_priority_arbiter (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // A flush request in RUN wins over any transfer in the same cycle.
    assign w_run      = (r_state == ST_RUN) && !bus.i_flush;
    assign w_wr_en    = w_run && w_grant_vld && !bus.i_fifo_full;
    assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

    // Forward the granted producer's word; zero when nothing is granted.
    always_comb begin
        w_wr_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_run && w_grant[k]) begin
                w_wr_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.o_ready        = w_wr_en ? w_grant : '0;
    assign bus.o_fifo_wr_en   = w_wr_en;
    assign bus.o_fifo_wr_data = w_wr_data;
    assign bus.o_fifo_clr     = r_clr;
    assign bus.o_busy         = r_busy;

    // Flush sequencer, rotation pointer and burst lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_clr      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef FIFO_ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.i_flush) begin
                        r_state  <= ST_CLR;
                        r_clr    <= 1'b1;
                        r_busy   <= 1'b1;
                        r_ptr    <= '0;
`ifdef FIFO_ARB_LOCK_EN
                        r_locked <= 1'b0;
`endif
                    end else if (w_wr_en) begin
                        r_ptr      <= w_next_ptr;
`ifdef FIFO_ARB_LOCK_EN
                        r_locked   <= ~|(bus.i_last & w_grant);
                        r_lock_idx <= w_grant_idx;
`endif
                    end
                end
                ST_CLR: begin
                    r_state <= ST_SETTLE;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b1;
                end
                ST_SETTLE: begin
                    r_state <= ST_RUN;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// tb/tb_sync_fifo_write_arbiter.sv - scoreboard bench for sync_fifo_write_arbiter with a queue-based FIFO model
module tb_sync_fifo_write_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic          wr;
        logic [NR-1:0] rdy;
        logic [DW-1:0] data;
        logic          clr;
        logic          busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    sync_fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t          exp_q[$];
    logic [DW-1:0] m_fifo[$];
    int            m_ptr  = 0;
    int            m_left = 0;
    int            m_lock = -1;
    int            checks = 0;
    int            failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // One cycle of stimulus; the expected DUT response is queued for the monitor.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic f, input logic rd);
        exp_t          e;
        int            g;
        int            idx;
        logic [NR-1:0] req;
        logic [NR-1:0] t;
        @(posedge clk);
        #1;
        bus.i_valid     = v;
        bus.i_last      = l;
        bus.i_flush     = f;
        bus.i_data      = (NR*DW)'($urandom);
        bus.i_fifo_full = (m_fifo.size() >= DEPTH);
        e.clr  = (m_left == 2);
        e.busy = (m_left > 0);
        e.wr   = 1'b0;
        e.rdy  = '0;
        e.data = '0;
        g = -1;
        if (m_left == 0 && !f) begin
            req = v;
            if (m_lock >= 0) req = v & (NR'(1) << m_lock);
            for (int n = 0; n < NR; n++) begin
                idx = (m_ptr + n) % NR;
                t = req >> idx;
                if (g < 0 && t[0]) g = idx;
            end
            if (g >= 0 && !bus.i_fifo_full) begin
                e.wr   = 1'b1;
                e.rdy  = NR'(1) << g;
                e.data = DW'(bus.i_data >> (g*DW));
            end
        end
        exp_q.push_back(e);
        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (e.wr) begin
            m_fifo.push_back(e.data);
            m_ptr = (g + 1) % NR;
`ifdef FIFO_ARB_LOCK_EN
            t = l >> g;
            m_lock = t[0] ? -1 : g;
`endif
        end
        if (m_left == 0 && f) begin
            m_left = 2;
            m_ptr  = 0;
            m_lock = -1;
        end else if (m_left > 0) begin
            if (m_left == 2) m_fifo.delete();
            m_left--;
        end
    endtask

    // Asynchronous reset between clock edges; state must drop immediately.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        bus.i_valid = '0;
        bus.i_flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, "_busy"}, 32'(bus.o_busy), 32'(0));
        check({tag, "_clr"}, 32'(bus.o_fifo_clr), 32'(0));
        check({tag, "_wr_en"}, 32'(bus.o_fifo_wr_en), 32'(0));
        check({tag, "_ready"}, 32'(bus.o_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_left = 0;
        m_lock = -1;
        m_fifo.delete();
    endtask

    // Monitor: compare DUT outputs against the queued expectation every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_en", 32'(bus.o_fifo_wr_en), 32'(e.wr));
                check("ready", 32'(bus.o_ready), 32'(e.rdy));
                check("fifo_clr", 32'(bus.o_fifo_clr), 32'(e.clr));
                check("busy", 32'(bus.o_busy), 32'(e.busy));
                if (e.wr) check("wr_data", 32'(bus.o_fifo_wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        bus.i_valid     = '0;
        bus.i_data      = '0;
        bus.i_last      = '0;
        bus.i_flush     = 1'b0;
        bus.i_fifo_full = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wr_en", 32'(bus.o_fifo_wr_en), 32'(0));
        check("rst_ready", 32'(bus.o_ready), 32'(0));
        check("rst_busy", 32'(bus.o_busy), 32'(0));
        check("rst_clr", 32'(bus.o_fifo_clr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Producers 0 and 2 fill an empty FIFO, then stall on full.
        for (int i = 0; i < 10; i++) step(4'b0101, 4'b1111, 1'b0, 1'b0);
        // Full FIFO, producer 1 waiting; one read frees exactly one slot.
        step(4'b0010, 4'b1111, 1'b0, 1'b0);
        step(4'b0010, 4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'b1111, 1'b0, 1'b0);
        // Flush coincident with producer 3; first grant afterwards goes to 0.
        step(4'b1000, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1001, 4'b1111, 1'b0, 1'b0);
        // All producers valid continuously with the FIFO drained each cycle.
        for (int i = 0; i < 14; i++) step(4'b1111, 4'b1111, 1'b0, 1'b1);
        // Burst from producer 1 while producer 0 competes.
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 1'b0, 1'b1);
        step(4'b0001, 4'b0001, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 1'b0, 1'b1);
        step(4'b0011, 4'b0011, 1'b0, 1'b1);
        step(4'b0011, 4'b0011, 1'b0, 1'b1);
        // Reset in the middle of a stream, then arbitration restarts at 0.
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b0000, 1'b0, 1'b1);
        async_reset("burst_rst");
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b0000, 1'b0, 1'b1);
        // Reset while the clear is in progress.
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        step(4'b0000, 4'b1111, 1'b0, 1'b1);
        async_reset("flush_rst");
        // Randomized traffic with occasional flushes and random reads.
        for (int i = 0; i < 600; i++) begin
            step(NR'($urandom), NR'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end
        step(4'b0000, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
